// File: rtl/gray_sum_pkg.sv
// rtl/gray_sum_pkg.sv - state encoding and datapath widths shared by gray_denorm_sum
package gray_sum_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      ALIGN = 2'b01,
      SUM   = 2'b10,
      DONE  = 2'b11
   } state_t;

   // Channel registers are Q8.9; three of them sum into a Q10.9 accumulator.
   localparam int CHAN_W = 17;
   localparam int ACC_W  = 19;

endpackage

// File: rtl/align_shifter.sv
// rtl/align_shifter.sv - one channel: latches mantissa, shifts one bit per cycle toward its exponent
module align_shifter
   import gray_sum_pkg::*;
#(
   parameter int MANT_WIDTH = 10,
   parameter int EXP_WIDTH  = 5
) (
   input  logic                  clk_i,
   input  logic                  rstn_i,
   input  logic                  i_load,
   input  logic                  i_shift,
   input  logic [MANT_WIDTH-1:0] i_mant,
   input  logic [EXP_WIDTH-1:0]  i_exp,
   output logic [EXP_WIDTH-1:0]  o_mag,
   output logic [CHAN_W-1:0]     o_chan,
   output logic                  o_ovf
);

   logic [CHAN_W-1:0]    r_chan;
   logic                 r_left;
   logic [EXP_WIDTH-1:0] r_cnt;
   logic                 r_ovf;
   logic [EXP_WIDTH-1:0] w_mag;
   logic                 w_left;

   // |-16| = 16 still fits the unsigned reading of EXP_WIDTH bits.
   assign w_mag  = i_exp[EXP_WIDTH-1] ? ((~i_exp) + EXP_WIDTH'(1)) : i_exp;
   assign w_left = ~i_exp[EXP_WIDTH-1] & (|i_exp);

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         r_chan <= '0;
         r_left <= 1'b0;
         r_cnt  <= '0;
         r_ovf  <= 1'b0;
      end else if (i_load) begin
         r_chan <= CHAN_W'(i_mant);
         r_left <= w_left;
         r_cnt  <= w_mag;
         r_ovf  <= 1'b0;
      end else if (i_shift && (r_cnt != '0)) begin
         r_cnt <= r_cnt - EXP_WIDTH'(1);
         if (r_left) begin
            r_chan <= {r_chan[CHAN_W-2:0], 1'b0};
            r_ovf  <= r_ovf | r_chan[CHAN_W-1];
         end else begin
            r_chan <= {1'b0, r_chan[CHAN_W-1:1]};
         end
      end
   end

   assign o_mag  = w_mag;
   assign o_chan = r_chan;
   assign o_ovf  = r_ovf;

endmodule

// File: rtl/gray_denorm_sum.sv
// rtl/gray_denorm_sum.sv - denormalises R/G/B mantissa+exponent pairs and sums them into a gray pixel
// Optional GRAY_ROUND_EN: round to nearest instead of truncating in SUM.
module gray_denorm_sum
   import gray_sum_pkg::*;
#(
   parameter int PIXEL_WIDTH = 8,
   parameter int MANT_WIDTH  = 10,
   parameter int EXP_WIDTH   = 5,
   parameter int FRAC_BITS   = 9
) (
   input  logic                   clk_i_gray_sum,
   input  logic                   rstn_i_gray_sum,
   input  logic                   start_i_gray_sum,
   input  logic [MANT_WIDTH-1:0]  data_i_sum_R,
   input  logic [MANT_WIDTH-1:0]  data_i_sum_G,
   input  logic [MANT_WIDTH-1:0]  data_i_sum_B,
   input  logic [EXP_WIDTH-1:0]   exp_i_sum_R,
   input  logic [EXP_WIDTH-1:0]   exp_i_sum_G,
   input  logic [EXP_WIDTH-1:0]   exp_i_sum_B,
   output logic [PIXEL_WIDTH-1:0] gray_o,
   output logic                   sat_o,
   output logic                   busy_o,
   output logic                   done_o
);

   localparam int INT_W = ACC_W - FRAC_BITS;

   state_t               r_state;
   state_t               w_next;
   logic [EXP_WIDTH-1:0] r_cnt;
   logic [EXP_WIDTH-1:0] w_n;
   logic                 w_load;
   logic                 w_shift;
   logic                 w_sum;
   logic [EXP_WIDTH-1:0] w_mag_r, w_mag_g, w_mag_b;
   logic [CHAN_W-1:0]    w_chan_r, w_chan_g, w_chan_b;
   logic                 w_ovf_r, w_ovf_g, w_ovf_b;
   logic [ACC_W-1:0]     w_acc;
   logic [ACC_W-1:0]     w_rnd;
   logic [INT_W-1:0]     w_int;
   logic                 w_sat;

   align_shifter #(.MANT_WIDTH(MANT_WIDTH), .EXP_WIDTH(EXP_WIDTH)) u_shift_r (
      .clk_i(clk_i_gray_sum), .rstn_i(rstn_i_gray_sum), .i_load(w_load), .i_shift(w_shift),
      .i_mant(data_i_sum_R), .i_exp(exp_i_sum_R), .o_mag(w_mag_r), .o_chan(w_chan_r), .o_ovf(w_ovf_r)
   );

   align_shifter #(.MANT_WIDTH(MANT_WIDTH), .EXP_WIDTH(EXP_WIDTH)) u_shift_g (
      .clk_i(clk_i_gray_sum), .rstn_i(rstn_i_gray_sum), .i_load(w_load), .i_shift(w_shift),
      .i_mant(data_i_sum_G), .i_exp(exp_i_sum_G), .o_mag(w_mag_g), .o_chan(w_chan_g), .o_ovf(w_ovf_g)
   );

   align_shifter #(.MANT_WIDTH(MANT_WIDTH), .EXP_WIDTH(EXP_WIDTH)) u_shift_b (
      .clk_i(clk_i_gray_sum), .rstn_i(rstn_i_gray_sum), .i_load(w_load), .i_shift(w_shift),
      .i_mant(data_i_sum_B), .i_exp(exp_i_sum_B), .o_mag(w_mag_b), .o_chan(w_chan_b), .o_ovf(w_ovf_b)
   );

   // ALIGN runs as long as the channel with the largest shift needs.
   always_comb begin
      w_n = w_mag_r;
      if (w_mag_g > w_n) w_n = w_mag_g;
      if (w_mag_b > w_n) w_n = w_mag_b;
   end

   always_ff @(posedge clk_i_gray_sum or negedge rstn_i_gray_sum) begin
      if (!rstn_i_gray_sum) r_state <= IDLE;
      else                  r_state <= w_next;
   end

   always_comb begin
      w_next  = r_state;
      w_load  = 1'b0;
      w_shift = 1'b0;
      w_sum   = 1'b0;
      case (r_state)
         IDLE: begin
            if (start_i_gray_sum) begin
               w_load = 1'b1;
               w_next = (w_n == '0) ? SUM : ALIGN;
            end
         end
         ALIGN: begin
            w_shift = 1'b1;
            if (r_cnt == EXP_WIDTH'(1)) w_next = SUM;
         end
         SUM: begin
            w_sum  = 1'b1;
            w_next = DONE;
         end
         DONE:    w_next = IDLE;
         default: w_next = IDLE;
      endcase
   end

   always_ff @(posedge clk_i_gray_sum or negedge rstn_i_gray_sum) begin
      if (!rstn_i_gray_sum)  r_cnt <= '0;
      else if (w_load)       r_cnt <= w_n;
      else if (w_shift)      r_cnt <= r_cnt - EXP_WIDTH'(1);
   end

   assign w_acc = ACC_W'(w_chan_r) + ACC_W'(w_chan_g) + ACC_W'(w_chan_b);

`ifdef GRAY_ROUND_EN
   assign w_rnd = w_acc + (ACC_W'(1) << (FRAC_BITS - 1));
`else
   assign w_rnd = w_acc;
`endif

   assign w_int = INT_W'(w_rnd >> FRAC_BITS);
   assign w_sat = w_ovf_r | w_ovf_g | w_ovf_b | (|w_int[INT_W-1:PIXEL_WIDTH]);

   always_ff @(posedge clk_i_gray_sum or negedge rstn_i_gray_sum) begin
      if (!rstn_i_gray_sum) begin
         gray_o <= '0;
         sat_o  <= 1'b0;
      end else if (w_sum) begin
         gray_o <= w_sat ? {PIXEL_WIDTH{1'b1}} : w_int[PIXEL_WIDTH-1:0];
         sat_o  <= w_sat;
      end
   end

   assign busy_o = (r_state != IDLE);
   assign done_o = (r_state == DONE);

endmodule

// File: doc/gray_denorm_sum.md
GRAY_DENORM_SUM -- requirements
Module: gray_denorm_sum

Interface
REQ-001 SHALL have parameter PIXEL_WIDTH, default 8, the output gray pixel width.
REQ-002 SHALL have parameter MANT_WIDTH, default 10, the input mantissa width (Q1.9, bit 9 is the integer bit).
REQ-003 SHALL have parameter EXP_WIDTH, default 5, the signed input exponent width.
REQ-004 SHALL have parameter FRAC_BITS, default 9, the number of mantissa fraction bits.
REQ-005 SHALL have port clk_i_gray_sum, input, 1 bit: the single clock, rising edge.
REQ-006 SHALL have port rstn_i_gray_sum, input, 1 bit: asynchronous, active-low reset.
REQ-007 SHALL have port start_i_gray_sum, input, 1 bit: request to convert the current inputs.
REQ-008 SHALL have ports data_i_sum_R, data_i_sum_G and data_i_sum_B, input, MANT_WIDTH bits each: unsigned channel mantissas.
REQ-009 SHALL have ports exp_i_sum_R, exp_i_sum_G and exp_i_sum_B, input, EXP_WIDTH bits each: signed channel exponents in the range -16..+15.
REQ-010 SHALL have port gray_o, output, PIXEL_WIDTH bits: the gray result.
REQ-011 SHALL have port sat_o, output, 1 bit: set when the result saturated.
REQ-012 SHALL have port busy_o, output, 1 bit: high whenever the block is not in IDLE.
REQ-013 SHALL have port done_o, output, 1 bit: a one-cycle completion pulse.

Function
REQ-014 Channel value SHALL be mant/2^9 * 2^exp; gray_o SHALL equal the integer part of the R+G+B sum after rounding per REQ-027, saturated to 255.
REQ-015 The state machine SHALL have states IDLE, ALIGN, SUM and DONE.
REQ-016 In IDLE, start high SHALL latch all six inputs into 17-bit Q8.9 channel registers (mantissa in bits [9:0]).
- The shift counter SHALL load N = max(|exp_R|, |exp_G|, |exp_B|).
- Next state SHALL be ALIGN, or SUM if N = 0.
REQ-017 In ALIGN, each channel SHALL shift one bit per cycle toward its own exponent: left if exp > 0, right if exp < 0.
- A channel SHALL hold once its own count is exhausted.
- The state SHALL leave after exactly N cycles.
REQ-018 On a left shift, a 1 shifted out of bit 16 SHALL set that channel's sticky overflow flag.
REQ-019 Right shifts SHALL truncate; exp = -16 SHALL yield 0.
REQ-020 In SUM (1 cycle), the three channels SHALL be added into a 19-bit accumulator, rounded, and registered into gray_o and sat_o.
REQ-021 sat_o SHALL be 1 if any overflow flag is set or the rounded integer part exceeds 255; in that case gray_o SHALL be 255.
REQ-022 DONE SHALL last 1 cycle, with done_o = 1 in it; the next state SHALL be IDLE.
REQ-023 Latency: done_o SHALL be high in the (N+2)th cycle after the start edge.
- gray_o and sat_o SHALL be valid while done_o is high and SHALL hold until the next SUM.
REQ-024 start while busy_o = 1 SHALL be ignored; start held high SHALL begin a new conversion from the IDLE cycle after DONE.

Reset
REQ-025 Reset low SHALL asynchronously force IDLE and clear gray_o, sat_o, busy_o, done_o, the channel registers, flags and counter to 0, including mid-conversion.
REQ-026 The first start SHALL be accepted no earlier than the first rising edge after reset deassertion.

Configuration
REQ-027 With GRAY_ROUND_EN defined, SUM SHALL add 2^8 (half LSB) before taking the integer bits; without it, SUM SHALL truncate.

Structure
REQ-028 Package gray_sum_pkg SHALL hold the state encoding (IDLE = 2'b00, ALIGN = 2'b01, SUM = 2'b10, DONE = 2'b11), the accumulator width (19) and the channel width (17).
REQ-029 Sub-module align_shifter (one channel: register, shift direction, remaining count, sticky overflow) SHALL be instantiated three times.

Verification
REQ-030 Reset: assert rstn mid-ALIGN -> next cycle IDLE, all outputs 0, no done_o.
REQ-031 Inputs R = 0x200/exp 7, G = 0x200/exp 6, B = 0x200/exp 5 -> gray_o = 224, sat_o = 0, done_o high 9 cycles after start.
REQ-032 Input R = 0x3FF/exp 8, G = B = 0 -> sat_o = 1, gray_o = 255.
REQ-033 Input R = 0x300/exp 0, G = B = 0x200/exp -16 -> gray_o = 2 with GRAY_ROUND_EN, 1 without; done_o 18 cycles after start.
REQ-034 Second start pulse during ALIGN -> ignored; exactly one done_o and result unchanged.
REQ-035 All exponents 0, mantissas 0x200 -> N = 0 skips ALIGN; gray_o = 3, done_o 2 cycles after start.
